// File: rtl/branch_resolve_if.sv
// Request / decision bundle between the ALU flag stage, the branch resolver
// and the fetch/PC logic. The master drives branch requests; the slave
// (branch_resolve) returns the decision, redirect, flush and statistics.
interface branch_resolve_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       br_op;
    logic             Z;
    logic             N;
    logic             V;
    logic [PC_W-1:0]  target;
    logic             done;
    logic             taken;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic             op_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output in_valid, br_op, Z, N, V, target,
        input  in_ready, done, taken, redirect_pc, flush, op_err,
               branch_cnt, taken_cnt
    );

    modport slave (
        input  in_valid, br_op, Z, N, V, target,
        output in_ready, done, taken, redirect_pc, flush, op_err,
               branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolver: captures ALU compare flags plus the decoded branch type,
// decides taken / not-taken one cycle later, issues a one-cycle redirect on
// a taken branch and then holds the front-end flush for FLUSH_CYCLES cycles.
// Keeps saturating counts of resolved and taken branches.
module branch_resolve #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    branch_resolve_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EVAL  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    // Returns {legal, taken} for a branch op; LT is the signed less-than
    // recovered from the subtract flags (negative unless it overflowed).
    function automatic logic [1:0] eval_cond(
        input logic [2:0] op,
        input logic       z,
        input logic       n,
        input logic       v
    );
        logic lt;
        lt = n ^ v;
        case (op)
            3'b000:  eval_cond = {1'b1, z};
            3'b001:  eval_cond = {1'b1, ~z};
            3'b010:  eval_cond = {1'b1, z | lt};
            3'b011:  eval_cond = {1'b1, ~z & ~lt};
            3'b100:  eval_cond = {1'b1, lt};
            3'b101:  eval_cond = {1'b1, ~lt};
            default: eval_cond = {1'b0, 1'b0};
        endcase
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             in_ready_r;
    logic [2:0]       op_r;
    logic             z_r;
    logic             n_r;
    logic             v_r;
    logic [PC_W-1:0]  target_r;
    logic             done_r;
    logic             taken_r;
    logic [PC_W-1:0]  redirect_pc_r;
    logic             flush_r;
    logic             op_err_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;
    logic [FC_W-1:0]  flush_cnt_r;
    logic [1:0]       cond_s;
    logic             legal_s;
    logic             taken_s;

    // Decision for the request currently held in the capture registers.
    always_comb begin
        cond_s  = eval_cond(op_r, z_r, n_r, v_r);
        legal_s = cond_s[1];
        taken_s = cond_s[0];
    end

    // Next-state selection; unknown encodings fall back to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = EVAL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EVAL: begin
                if (taken_s) begin
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == {FC_W{1'b0}}) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = FLUSH;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, request capture, decision outputs, flush timer and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b1;
            op_r          <= 3'b000;
            z_r           <= 1'b0;
            n_r           <= 1'b0;
            v_r           <= 1'b0;
            target_r      <= {PC_W{1'b0}};
            done_r        <= 1'b0;
            taken_r       <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
            flush_r       <= 1'b0;
            op_err_r      <= 1'b0;
            branch_cnt_r  <= {CNT_W{1'b0}};
            taken_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r   <= {FC_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s == IDLE);
            done_r     <= 1'b0;
            taken_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r     <= bus.br_op;
                        z_r      <= bus.Z;
                        n_r      <= bus.N;
                        v_r      <= bus.V;
                        target_r <= bus.target;
                    end
                end
                EVAL: begin
                    done_r      <= 1'b1;
                    taken_r     <= taken_s;
                    flush_r     <= taken_s;
                    flush_cnt_r <= FC_W'(FLUSH_CYCLES - 1);
                    if (taken_s) begin
                        redirect_pc_r <= target_r;
                    end
                    if (!legal_s) begin
                        op_err_r <= 1'b1;
                    end
                    if (branch_cnt_r != {CNT_W{1'b1}}) begin
                        branch_cnt_r <= branch_cnt_r + CNT_W'(1'b1);
                    end
                    if (taken_s && (taken_cnt_r != {CNT_W{1'b1}})) begin
                        taken_cnt_r <= taken_cnt_r + CNT_W'(1'b1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r == {FC_W{1'b0}}) begin
                        flush_r <= 1'b0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - FC_W'(1'b1);
                    end
                end
                default: begin
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.done        = done_r;
    assign bus.taken       = taken_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.flush       = flush_r;
    assign bus.op_err      = op_err_r;
    assign bus.branch_cnt  = branch_cnt_r;
    assign bus.taken_cnt   = taken_cnt_r;
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve. Expected decisions come from
// signed comparisons of random operands; the flags fed to the DUT are
// derived from the subtraction A-B.
module tb_branch_resolve;
    localparam int FC = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // expected model state
    int          exp_bc;
    int          exp_tc;
    logic        exp_err;
    logic [31:0] exp_redirect;

    branch_resolve_if #(.PC_W(32), .CNT_W(16)) bus ();
    branch_resolve_if #(.PC_W(32), .CNT_W(2))  bus_s ();

    branch_resolve #(.PC_W(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    branch_resolve #(.PC_W(32), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_bc = 0; exp_tc = 0; exp_err = 1'b0; exp_redirect = 32'h0;
    endtask

    // Drive one request at a negedge with in_ready=1; return at EVAL negedge.
    task automatic issue(input logic [2:0] op, input logic z, input logic n,
                         input logic v, input logic [31:0] tgt);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL issue_ready_timeout got in_ready=%b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.br_op = op; bus.Z = z; bus.N = n; bus.V = v; bus.target = tgt;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic int sat_inc(input int c, input int maxv);
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    task automatic test_reset;
        do_reset(2);
        checks += 7;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b want 0", bus.flush); end
        if (bus.op_err !== 1'b0) begin errors++; $display("FAIL rst_op_err got %b want 0", bus.op_err); end
        if (bus.branch_cnt !== 16'd0) begin errors++; $display("FAIL rst_branch_cnt got %0d want 0", bus.branch_cnt); end
        if (bus.taken_cnt !== 16'd0) begin errors++; $display("FAIL rst_taken_cnt got %0d want 0", bus.taken_cnt); end
        if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect got %h want 0", bus.redirect_pc); end
    endtask

    task automatic test_beq_taken;
        issue(3'b000, 1'b1, 1'b0, 1'b0, 32'h0040_0020);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL beq_eval_done got %b want 0", bus.done); end
        @(negedge clk);   // T+2
        exp_bc++; exp_tc++; exp_redirect = 32'h0040_0020;
        checks += 5;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL beq_done got %b want 1", bus.done); end
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b want 1", bus.taken); end
        if (bus.redirect_pc !== 32'h0040_0020) begin errors++; $display("FAIL beq_redirect got %h want 00400020", bus.redirect_pc); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush_t2 got %b want 1", bus.flush); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL beq_ready_t2 got %b want 0", bus.in_ready); end
        @(negedge clk);   // T+3
        checks += 3;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL beq_done_t3 got %b want 0", bus.done); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush_t3 got %b want 1", bus.flush); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL beq_ready_t3 got %b want 0", bus.in_ready); end
        @(negedge clk);   // T+4
        checks += 2;
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_flush_t4 got %b want 0", bus.flush); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL beq_ready_t4 got %b want 1", bus.in_ready); end
    endtask

    task automatic test_bgtz;
        int bc0;
        int tc0;
        bc0 = exp_bc; tc0 = exp_tc;
        issue(3'b011, 1'b0, 1'b1, 1'b1, 32'h0000_1000);   // LT=0, Z=0 -> taken
        @(negedge clk);
        exp_bc++; exp_tc++; exp_redirect = 32'h0000_1000;
        checks++;
        if (bus.taken !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL bgtz_taken got done=%b taken=%b want 1 1", bus.done, bus.taken); end
        issue(3'b011, 1'b0, 1'b1, 1'b0, 32'h0000_2000);   // LT=1 -> not taken
        @(negedge clk);
        exp_bc++;
        checks += 5;
        if (bus.done !== 1'b1 || bus.taken !== 1'b0) begin errors++; $display("FAIL bgtz_nt got done=%b taken=%b want 1 0", bus.done, bus.taken); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bgtz_nt_ready got %b want 1", bus.in_ready); end
        if (bus.redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL bgtz_redirect_hold got %h want 00001000", bus.redirect_pc); end
        if (int'(bus.branch_cnt) !== bc0 + 2) begin errors++; $display("FAIL bgtz_branch_cnt got %0d want %0d", bus.branch_cnt, bc0 + 2); end
        if (int'(bus.taken_cnt) !== tc0 + 1) begin errors++; $display("FAIL bgtz_taken_cnt got %0d want %0d", bus.taken_cnt, tc0 + 1); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, diff, tgt;
        logic [2:0]  op;
        logic        z, n, v, et, ill, efl, erdy;
        int          r;
        for (int i = 0; i < 60; i++) begin
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) b = 32'h0;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            r = $urandom_range(0, 13);
            op = (r < 12) ? 3'(r % 6) : 3'(6 + r - 12);
            tgt = $urandom();
            diff = a - b;
            z = (diff == 32'h0);
            n = diff[31];
            v = (a[31] != b[31]) && (diff[31] != a[31]);
            ill = 1'b0;
            case (op)
                3'd0: et = (a == b);
                3'd1: et = (a != b);
                3'd2: et = ($signed(a) <= $signed(b));
                3'd3: et = ($signed(a) >  $signed(b));
                3'd4: et = ($signed(a) <  $signed(b));
                3'd5: et = ($signed(a) >= $signed(b));
                default: begin et = 1'b0; ill = 1'b1; end
            endcase
            issue(op, z, n, v, tgt);
            @(negedge clk);   // T+2
            exp_bc = sat_inc(exp_bc, 65535);
            if (et) begin exp_tc = sat_inc(exp_tc, 65535); exp_redirect = tgt; end
            if (ill) exp_err = 1'b1;
            checks += 6;
            if (bus.done !== 1'b1) begin errors++; $display("FAIL rnd_done[%0d] got %b want 1", i, bus.done); end
            if (bus.taken !== et) begin errors++; $display("FAIL rnd_taken[%0d] op=%0d got %b want %b", i, op, bus.taken, et); end
            if (bus.redirect_pc !== exp_redirect) begin errors++; $display("FAIL rnd_redirect[%0d] got %h want %h", i, bus.redirect_pc, exp_redirect); end
            if (int'(bus.branch_cnt) !== exp_bc) begin errors++; $display("FAIL rnd_branch_cnt[%0d] got %0d want %0d", i, bus.branch_cnt, exp_bc); end
            if (int'(bus.taken_cnt) !== exp_tc) begin errors++; $display("FAIL rnd_taken_cnt[%0d] got %0d want %0d", i, bus.taken_cnt, exp_tc); end
            if (bus.op_err !== exp_err) begin errors++; $display("FAIL rnd_op_err[%0d] got %b want %b", i, bus.op_err, exp_err); end
            for (int k = 0; k <= FC; k++) begin
                efl  = et && (k < FC);
                erdy = !efl;
                checks += 2;
                if (bus.flush !== efl) begin errors++; $display("FAIL rnd_flush[%0d,%0d] got %b want %b", i, k, bus.flush, efl); end
                if (bus.in_ready !== erdy) begin errors++; $display("FAIL rnd_ready[%0d,%0d] got %b want %b", i, k, bus.in_ready, erdy); end
                if (k > 0) begin
                    checks++;
                    if (bus.done !== 1'b0) begin errors++; $display("FAIL rnd_done_pulse[%0d,%0d] got %b want 0", i, k, bus.done); end
                end
                if (erdy) break;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_hold_valid;
        int bc0;
        bc0 = exp_bc;
        bus.in_valid = 1'b1; bus.br_op = 3'b000; bus.Z = 1'b1; bus.N = 1'b0; bus.V = 1'b0;
        bus.target = 32'h0000_ABC0;
        @(posedge clk);           // accept at T
        @(negedge clk);           // T+1
        @(negedge clk);           // T+2
        checks++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_t2 got done=%b ready=%b want 1 0", bus.done, bus.in_ready); end
        @(negedge clk);           // T+3
        checks += 2;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_t3_done got %b want 0", bus.done); end
        if (int'(bus.branch_cnt) !== bc0 + 1) begin errors++; $display("FAIL hold_t3_cnt got %0d want %0d", bus.branch_cnt, bc0 + 1); end
        @(negedge clk);           // T+4: ready again, second accept at its end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_t4_ready got %b want 1", bus.in_ready); end
        @(negedge clk);           // T+5: EVAL of second
        bus.in_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || int'(bus.branch_cnt) !== bc0 + 1) begin errors++; $display("FAIL hold_t5 got done=%b cnt=%0d want 0 %0d", bus.done, bus.branch_cnt, bc0 + 1); end
        @(negedge clk);           // T+6
        exp_bc += 2; exp_tc += 2; exp_redirect = 32'h0000_ABC0;
        checks++;
        if (bus.done !== 1'b1 || int'(bus.branch_cnt) !== exp_bc) begin errors++; $display("FAIL hold_t6 got done=%b cnt=%0d want 1 %0d", bus.done, bus.branch_cnt, exp_bc); end
        repeat (FC) @(negedge clk);
    endtask

    task automatic test_illegal;
        issue(3'b110, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        @(negedge clk);
        exp_bc++; exp_err = 1'b1;
        checks += 3;
        if (bus.done !== 1'b1 || bus.taken !== 1'b0) begin errors++; $display("FAIL ill_decision got done=%b taken=%b want 1 0", bus.done, bus.taken); end
        if (bus.op_err !== 1'b1) begin errors++; $display("FAIL ill_op_err got %b want 1", bus.op_err); end
        if (bus.flush !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_flow got flush=%b ready=%b want 0 1", bus.flush, bus.in_ready); end
        issue(3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_0080);   // legal BNE, not taken
        @(negedge clk);
        exp_bc++;
        checks++;
        if (bus.op_err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b want 1", bus.op_err); end
    endtask

    task automatic test_saturate;
        int sbc;
        int stc;
        int guard;
        sbc = 0; stc = 0;
        for (int i = 0; i < 5; i++) begin
            bus_s.in_valid = 1'b1; bus_s.br_op = 3'b001; bus_s.Z = 1'b0;
            bus_s.N = 1'b0; bus_s.V = 1'b0; bus_s.target = 32'h100 + 32'(i);
            @(posedge clk);
            @(negedge clk);
            bus_s.in_valid = 1'b0;
            @(negedge clk);
            sbc = sat_inc(sbc, 3); stc = sat_inc(stc, 3);
            checks += 2;
            if (bus_s.done !== 1'b1 || bus_s.taken !== 1'b1) begin errors++; $display("FAIL sat_decision[%0d] got done=%b taken=%b want 1 1", i, bus_s.done, bus_s.taken); end
            if (int'(bus_s.branch_cnt) !== sbc || int'(bus_s.taken_cnt) !== stc) begin errors++; $display("FAIL sat_cnt[%0d] got %0d/%0d want %0d/%0d", i, bus_s.branch_cnt, bus_s.taken_cnt, sbc, stc); end
            guard = 0;
            while (bus_s.in_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
            checks++;
            if (guard >= 20) begin errors++; $display("FAIL sat_ready_timeout[%0d] got 0 want 1", i); end
        end
    endtask

    task automatic test_reset_mid_flush;
        issue(3'b100, 1'b0, 1'b1, 1'b0, 32'h0000_0300);   // BLTZ, LT=1 -> taken
        @(negedge clk);   // T+2, in FLUSH
        checks++;
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL midrst_pre_flush got %b want 1", bus.flush); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_bc = 0; exp_tc = 0; exp_err = 1'b0; exp_redirect = 32'h0;
        checks += 5;
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL midrst_flush got %b want 0", bus.flush); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.in_ready); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        if (bus.branch_cnt !== 16'd0 || bus.taken_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", bus.branch_cnt, bus.taken_cnt); end
        if (bus.op_err !== 1'b0) begin errors++; $display("FAIL midrst_op_err got %b want 0", bus.op_err); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.br_op = 3'b000; bus.Z = 1'b0; bus.N = 1'b0; bus.V = 1'b0; bus.target = 32'h0;
        bus_s.in_valid = 1'b0; bus_s.br_op = 3'b000; bus_s.Z = 1'b0; bus_s.N = 1'b0; bus_s.V = 1'b0; bus_s.target = 32'h0;
        test_reset();
        test_beq_taken();
        test_bgtz();
        test_hold_valid();
        test_illegal();
        test_random();
        test_saturate();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
